camac_cycle_responder: RTL

CAMAC-side responder for the SM2201 ISA–CAMAC interface board; the far end of the strobe sequence issued by `micro_program_automate`. It qualifies each cycle with `sel2`, latches function and subaddress on the S1 strobe (`c1`), and executes the transfer on the S2 strobe (`c2`) against four 16-bit registers and a status word. It returns the completion/X response on `cx1`, the Q response on `q`, and reports cycles aborted by a watchdog.

---
 rtl/camac_cycle_responder_if.sv | 26 ++
 rtl/camac_cycle_responder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/camac_cycle_responder_if.sv
// CAMAC dataway signals between the strobe automate (master) and the
// cycle responder (slave).
interface camac_cycle_responder_if;
    logic        sel2;
    logic        c1;
    logic        c2;
    logic        x0;
    logic        x1;
    logic [1:0]  sa;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        cx1;
    logic        q;
    logic        busy;
    logic        err;

    modport master (
        output sel2, c1, c2, x0, x1, sa, wdata,
        input  rdata, cx1, q, busy, err
    );

    modport slave (
        input  sel2, c1, c2, x0, x1, sa, wdata,
        output rdata, cx1, q, busy, err
    );
endinterface

// File: rtl/camac_cycle_responder.sv
// CAMAC-side responder: latches function/subaddress on the S1 strobe, runs the
// transfer on S2 against four 16-bit registers, answers with X/Q, guards S2 with a watchdog.
module camac_cycle_responder #(
    parameter int TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    camac_cycle_responder_if.slave        bus
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_S2 = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;

    localparam logic [1:0] F_READ   = 2'b00;
    localparam logic [1:0] F_WRITE  = 2'b01;
    localparam logic [1:0] F_STATUS = 2'b10;
    localparam logic [1:0] F_CLEAR  = 2'b11;

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic            c1_q, c2_q;
    logic [1:0]      f_q, f_d;
    logic [1:0]      sa_q, sa_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [11:0]     cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [15:0]     rdata_q, rdata_d;
    logic            q_q, q_d;
    logic [15:0]     regs_q [4];
    logic [15:0]     regs_d [4];

    logic c1_rise;
    logic c2_rise;

    // Edges are qualified by the cycle select; the strobe copies track regardless.
    assign c1_rise = bus.c1 & ~c1_q & bus.sel2;
    assign c2_rise = bus.c2 & ~c2_q & bus.sel2;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        f_d     = f_q;
        sa_d    = sa_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        q_d     = q_q;
        regs_d  = regs_q;

        case (state_q)
            ST_IDLE: begin
                if (c1_rise) begin
                    f_d     = {bus.x1, bus.x0};
                    sa_d    = bus.sa;
                    wd_d    = '0;
                    state_d = ST_WAIT_S2;
                end
            end

            ST_WAIT_S2: begin
                if (!bus.sel2) begin
                    state_d = ST_IDLE;
                end else if (c1_rise) begin
                    f_d  = {bus.x1, bus.x0};
                    sa_d = bus.sa;
                    wd_d = '0;
                end else if (c2_rise) begin
                    state_d = ST_ACK;
                    cnt_d   = cnt_q + 12'd1;
                    q_d     = 1'b1;
                    case (f_q)
                        F_READ:   rdata_d = regs_q[sa_q];
                        F_WRITE:  regs_d[sa_q] = bus.wdata;
                        F_STATUS: rdata_d = {err_q, 3'b000, cnt_q};
                        F_CLEAR: begin
                            cnt_d = '0;
                            err_d = 1'b0;
                            q_d   = 1'b0;
                        end
                        default: ;
                    endcase
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            ST_ACK: begin
                // Strobe edges are deliberately ignored here; only deselect ends the cycle.
                if (!bus.sel2) begin
                    state_d = ST_IDLE;
                    q_d     = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            c1_q    <= 1'b0;
            c2_q    <= 1'b0;
            f_q     <= '0;
            sa_q    <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            q_q     <= 1'b0;
            // NOTE: the register file is small and must read zero after reset, so it is reset explicitly.
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            c1_q    <= bus.c1;
            c2_q    <= bus.c2;
            f_q     <= f_d;
            sa_q    <= sa_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            q_q     <= q_d;
            regs_q  <= regs_d;
        end
    end

    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.cx1   = (state_q == ST_ACK);
    assign bus.q     = q_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

endmodule
